// File: rtl/codec_serial_port_pkg.sv
// rtl/codec_serial_port_pkg.sv - shared constants, strobe bundle and slot helper for the codec serial port
// Purpose: default frame geometry for the I2S-style codec link. It also holds the
//          decoded timing strobe bundle that passes from the frame timer to the datapath.
// Ports:   none (package)
package codec_serial_port_pkg;

  localparam int DEF_SAMPLE_W = 16;   // audio word width, MSB first, <= 31
  localparam int DEF_BCLK_DIV = 8;    // clk cycles per bclk period, even, >= 4
  localparam int SLOT_BITS    = 32;   // bclk periods per slot
  localparam int SLOTS        = 2;    // left + right
  localparam int COUNT_W      = 16;   // SampleCount width

  // One-clk strobes. Each strobe is high during the cycle whose closing edge performs the action.
  typedef struct packed {
    logic rx_shift;   // closing edge is the bclk-rise sample point of a left data slot
    logic tx_shift;   // closing edge enters bclk fall of a data slot: present next DAC bit
    logic bit_fall;   // closing edge enters bclk fall of any slot
    logic ready_pre;  // closing edge enters mid-frame: publish SampleIn
    logic tx_load;    // closing edge wraps the frame: latch SampleOut
  } frame_strobes_t;

  function automatic int frame_clks(input int bclk_div);
    return SLOTS * SLOT_BITS * bclk_div;
  endfunction

  // Slot b carries data when (b mod 32) is in 1..w, in either half of the frame.
  function automatic logic data_slot(input int b, input int w);
    return ((b % SLOT_BITS) >= 1) && ((b % SLOT_BITS) <= w);
  endfunction

endpackage

// File: rtl/codec_serial_port_if.sv
// rtl/codec_serial_port_if.sv - parallel sample interface between the codec port and the voice changer
// Purpose: groups the word-level handshake of the codec boundary.
// Ports (signals):
//   ready        1-clk strobe, new SampleIn valid
//   SampleIn     captured ADC word, held until the next ready
//   SampleCount  number of ready strobes since reset (16 bit, wraps)
//   SampleOut    processed sample returned for the DAC
// Modports: master = codec port, slave = sample consumer/producer
interface codec_serial_port_if #(
  parameter int SAMPLE_W = 16
);
  logic                ready;
  logic [SAMPLE_W-1:0] SampleIn;
  logic [15:0]         SampleCount;
  logic [SAMPLE_W-1:0] SampleOut;

  modport master (output ready, SampleIn, SampleCount, input SampleOut);
  modport slave  (input ready, SampleIn, SampleCount, output SampleOut);
endinterface

// File: rtl/codec_frame_timer.sv
// rtl/codec_frame_timer.sv - free-running frame counter with bclk/lrclk generation and slot strobes
// Purpose: counts 0..FRAME_CLKS-1 and decodes slot b = cnt/BCLK_DIV and phase p = cnt%BCLK_DIV.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   bclk        bit clock, high for p >= BCLK_DIV/2
//   lrclk       0 = left slot (b < 32), 1 = right slot
//   strb        one-clk timing strobes for the datapath
module codec_frame_timer
  import codec_serial_port_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic           clk,
  input  logic           reset,
  output logic           bclk,
  output logic           lrclk,
  output frame_strobes_t strb
);

  localparam int FRAME_CLKS = frame_clks(BCLK_DIV);
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam int HALF       = BCLK_DIV / 2;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  int               nb;
  int               np;

  // Every output is registered from the decode of cnt_nxt. Each output then follows
  // cnt exactly and is still a flop output, so it is free of glitches.
  always_comb begin
    cnt_nxt = (cnt == CNT_W'(FRAME_CLKS - 1)) ? '0 : cnt + 1'b1;
    nb      = int'(cnt_nxt) / BCLK_DIV;
    np      = int'(cnt_nxt) % BCLK_DIV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      bclk  <= 1'b0;
      lrclk <= 1'b0;
      strb  <= '0;
    end else begin
      cnt            <= cnt_nxt;
      bclk           <= (np >= HALF);
      lrclk          <= (nb >= SLOT_BITS);
      strb.rx_shift  <= (np == HALF) && (nb >= 1) && (nb <= SAMPLE_W);
      // The last phase of slot nb precedes the falling edge that starts slot nb+1.
      strb.tx_shift  <= (np == BCLK_DIV - 1) && data_slot(nb + 1, SAMPLE_W);
      strb.bit_fall  <= (np == BCLK_DIV - 1);
      strb.ready_pre <= (cnt_nxt == CNT_W'(FRAME_CLKS / 2 - 1));
      strb.tx_load   <= (cnt_nxt == CNT_W'(FRAME_CLKS - 1));
    end
  end

endmodule

// File: rtl/codec_serial_port.sv
// rtl/codec_serial_port.sv - I2S-style codec link: ADC deserialiser, DAC serialiser, sample strobe
// Purpose: captures the left-slot ADC word each frame. It presents the word as SampleIn with a
//          ready strobe and counts the strobes. It sends SampleOut MSB first in both DAC slots.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   adc_sdata   serial ADC data, sampled at bclk rise
//   bclk, lrclk bit clock and slot select
//   dac_sdata   serial DAC data, changes on bclk fall
//   sp          sample interface (ready, SampleIn, SampleCount out; SampleOut in)
module codec_serial_port
  import codec_serial_port_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int BCLK_DIV = DEF_BCLK_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_sdata,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 dac_sdata,
  codec_serial_port_if.master  sp
);

  frame_strobes_t      strb;
  logic [SAMPLE_W-1:0] rx_shreg;
  logic [SAMPLE_W-1:0] tx_shreg;
  logic [SAMPLE_W-1:0] sample_in;
  logic [COUNT_W-1:0]  sample_count;
  logic                ready;

  codec_frame_timer #(
    .SAMPLE_W (SAMPLE_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .bclk  (bclk),
    .lrclk (lrclk),
    .strb  (strb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shreg     <= '0;
      tx_shreg     <= '0;
      sample_in    <= '0;
      sample_count <= '0;
      ready        <= 1'b0;
      dac_sdata    <= 1'b0;
    end else begin
      ready <= strb.ready_pre;

      if (strb.rx_shift) begin
        rx_shreg <= {rx_shreg[SAMPLE_W-2:0], adc_sdata};
      end

      if (strb.ready_pre) begin
        sample_in    <= rx_shreg;
        sample_count <= sample_count + 1'b1;
      end

      // The word rotates instead of shifting. After SAMPLE_W bits of the left slot it is
      // back in place, so the right slot repeats the same word.
      if (strb.tx_load) begin
        tx_shreg <= sp.SampleOut;
      end else if (strb.tx_shift) begin
        tx_shreg <= {tx_shreg[SAMPLE_W-2:0], tx_shreg[SAMPLE_W-1]};
      end

      if (strb.tx_shift) begin
        dac_sdata <= tx_shreg[SAMPLE_W-1];
      end else if (strb.bit_fall) begin
        dac_sdata <= 1'b0;
      end
    end
  end

  assign sp.ready       = ready;
  assign sp.SampleIn    = sample_in;
  assign sp.SampleCount = sample_count;

endmodule

// File: tb/tb_codec_serial_port.sv
// tb/tb_codec_serial_port.sv - randomized self-checking bench for codec_serial_port
module tb_codec_serial_port;

  localparam int W     = 16;
  localparam int DIV   = 8;
  localparam int FRAME = 64 * DIV;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic adc_sdata = 1'b0;
  logic bclk;
  logic lrclk;
  logic dac_sdata;

  codec_serial_port_if #(.SAMPLE_W(W)) sp ();

  codec_serial_port dut (
    .clk       (clk),
    .reset     (reset),
    .adc_sdata (adc_sdata),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .dac_sdata (dac_sdata),
    .sp        (sp)
  );

  always #5 clk = ~clk;

  // reference model state
  int           mcnt;
  logic [W-1:0] cur_tx, next_tx, exp_in, frame_l, frame_r;
  logic [15:0]  exp_count;
  int           adc_mode;   // 0 random words, 1 fixed words, 2 serial loopback
  int           so_mode;    // 0 SampleOut churns randomly, 1 held at fixed_so
  logic [W-1:0] fixed_l, fixed_r, fixed_so;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s got=%h exp=%h at frame pos %0d", tag, got, exp, mcnt);
    end
  endtask

  // Advance one clock. Update the model, compare the DUT outputs, then drive inputs for this cycle.
  task automatic step();
    logic rst_s;
    logic exp_dac;
    int   b, p, sb;
    rst_s = reset;
    @(posedge clk);
    #1;
    if (rst_s) begin
      mcnt      = 0;
      cur_tx    = '0;
      next_tx   = '0;
      exp_in    = '0;
      exp_count = '0;
    end else begin
      mcnt = (mcnt + 1) % FRAME;
      if (mcnt == 0) cur_tx = next_tx;
      if (mcnt == FRAME / 2) begin
        exp_in = (adc_mode == 2) ? cur_tx : frame_l;
        exp_count++;
      end
    end

    b  = mcnt / DIV;
    p  = mcnt % DIV;
    sb = b % 32;
    exp_dac = 1'b0;
    if (sb >= 1 && sb <= W) exp_dac = cur_tx[W - sb];

    check("bclk",        32'(bclk),           32'(p >= DIV / 2));
    check("lrclk",       32'(lrclk),          32'(b >= 32));
    check("ready",       32'(sp.ready),       32'(mcnt == FRAME / 2));
    check("dac_sdata",   32'(dac_sdata),      32'(exp_dac));
    check("SampleIn",    32'(sp.SampleIn),    32'(exp_in));
    check("SampleCount", 32'(sp.SampleCount), 32'(exp_count));

    if (mcnt == 0) begin
      frame_l = (adc_mode == 1) ? fixed_l : W'($urandom);
      frame_r = (adc_mode == 1) ? fixed_r : W'($urandom);
    end
    if (adc_mode == 2) begin
      adc_sdata = dac_sdata;
    end else if (b >= 1 && b <= W) begin
      adc_sdata = frame_l[W - b];
    end else if (b >= 33 && b <= 32 + W) begin
      adc_sdata = frame_r[32 + W - b];
    end else begin
      adc_sdata = 1'($urandom_range(0, 1));
    end

    if (so_mode == 1) sp.SampleOut = fixed_so;
    else if ($urandom_range(0, 3) == 0) sp.SampleOut = W'($urandom);
    if (mcnt == FRAME - 1) next_tx = sp.SampleOut;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < FRAME; i++) begin
      if (mcnt == target) break;
      step();
    end
  endtask

  initial begin
    mcnt         = 0;
    cur_tx       = '0;
    next_tx      = '0;
    exp_in       = '0;
    exp_count    = '0;
    frame_l      = '0;
    frame_r      = '0;
    adc_mode     = 0;
    so_mode      = 0;
    fixed_l      = 16'hA5C3;
    fixed_r      = 16'hFFFF;
    fixed_so     = 16'h8001;
    sp.SampleOut = '0;

    // power-on reset for two clocks, then random traffic
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    run(6 * FRAME);

    // fixed ADC words and a held DAC word
    adc_mode = 1;
    so_mode  = 1;
    run(3 * FRAME);

    // reset in the middle of the left-slot capture
    adc_mode = 0;
    so_mode  = 0;
    run_until(100);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    run(3 * FRAME);

    // serial loopback, aligned to a frame boundary
    run_until(FRAME - 1);
    adc_mode = 2;
    run(5 * FRAME);

    // SampleCount wrap: preload just below the top, away from the ready strobe
    run_until(300);
    force dut.sample_count = 16'hFFFE;
    exp_count = 16'hFFFE;
    step();
    release dut.sample_count;
    run(3 * FRAME);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
